decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered MIPS-I instruction decode stage with a valid/ready handshake on both sides.
- Produces the 14-bit control bundle plus decoded register fields, destination register, extended immediate and PC for the execute stage.
- Adds three things a purely combinational decoder does not have: illegal-instruction flagging, parametrised load-use interlock (bubble insertion), and saturating issue/stall performance counters.

Parameters:
- PC_W, default 32, width of the PC carried alongside the instruction.
- LOAD_DELAY, default 1, bubbles required between a load and a dependent consumer. 0 disables the interlock.
- CNT_W, default 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction address.
- flush  in  1  kill the held instruction and all interlock state.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute stage accepts the bundle.
- out_ctrl  out  14  control bundle.
- out_rs, out_rt, out_rd  out  5 each  raw instruction fields.
- out_dst  out  5  write-back register.
- out_imm  out  32  extended immediate.
- out_pc  out  PC_W  registered in_pc.
- out_illegal  out  1  undefined op/func/rt encoding.
- issue_cnt  out  CNT_W  instructions accepted.
- stall_cnt  out  CNT_W  cycles in_ready held low by a hazard.

Behaviour:
- Reset (rst_n=0 at clk edge): every output register clears to 0, owed counter clears to 0, both perf counters clear to 0.
- Control bundle layout, from bit 13 down: ALUOp[13:10], ALUSrc[9], RegDst[8:7] (00 rt, 01 rd, 10 r31), Size[6:5] (00 word, 01 half, 10 byte), MemWrite[4], MemRead[3], LoadSigned[2], MemtoReg[1], NoWB[0] (1 = no register write).
- Decode, R-type (op 000000):
  - sll/srl/sra/sllv/srlv/srav/add/addu/sub/subu/and/or/xor/nor/slt/sltu -> ALUOp 0000, RegDst 01, rest 0.
  - jr -> NoWB=1, rest 0.
  - jalr -> RegDst 10, rest 0.
- Decode, REGIMM (op 000001), selected by rt:
  - bltz/bgez -> ALUOp 0001, NoWB=1.
  - bltzal/bgezal -> ALUOp 0001, RegDst 10.
- Decode, jumps and branches:
  - j/beq/bne/blez/bgtz -> ALUOp 0001, NoWB=1.
  - jal -> ALUOp 0001, RegDst 10.
- Decode, immediates: addi, addiu, slti, sltiu, andi, ori, xori, lui -> ALUOp 0001 through 1000 in that order, ALUSrc=1.
- Decode, loads: lb/lbu/lh/lhu/lw -> ALUOp 0001, ALUSrc=1, Size per width, MemRead=1, MemtoReg=1, LoadSigned=1 only for lb/lh.
- Decode, stores: sb/sh/sw -> ALUOp 0001, ALUSrc=1, Size per width, MemWrite=1, NoWB=1.
- Any other encoding -> ctrl=0 and out_illegal=1. The instruction still issues, so the exception is taken downstream.
- out_imm:
  - andi/ori/xori -> zero-extended.
  - lui -> imm<<16.
  - everything else -> sign-extended.
- out_dst is selected by RegDst. It is forced to 0 when NoWB=1 or illegal.
- Source usage:
  - rs_used for all opcodes except j, jal and lui.
  - rt_used for R-type, beq, bne and stores.
- Definitions used below:
  - slot_free = !out_valid || out_ready.
  - owed = down-counter of bubbles still required after the last accepted load.
  - hazard = in_valid && owed>0 && ld_dst!=0 && ((rs_used && rs==ld_dst) || (rt_used && rt==ld_dst)).
- Handshake: in_ready = slot_free && !flush && !hazard. This is combinational.
- Accept (in_valid && in_ready):
  - Output registers load the decode with out_valid=1, one-cycle latency.
  - For a load with out_dst!=0: owed<=LOAD_DELAY, ld_dst<=out_dst.
  - Any other instruction: owed<=0.
  - issue_cnt increments.
- slot_free but no accept: out_valid<=0 (bubble). owed decrements if nonzero. Idle cycles therefore count as bubbles.
- !slot_free: output registers and owed are held stable, even when in_valid changes.
- Stall counting: stall_cnt increments in every cycle with hazard && slot_free && !flush.
- Both perf counters saturate at all-ones; they do not wrap.
- flush (priority over everything except reset):
  - out_valid<=0, owed<=0, in_ready=0.
  - Perf counters are unchanged.
- Reset mid-stall returns the stage to empty with owed=0.

Test Plan:
- Reset, then addi $3,$2,-4 (0x2043FFFC) -> next cycle out_valid=1, out_ctrl=14'b0001_1_00_00_0_0_0_0_0, out_dst=3, out_imm=0xFFFFFFFC, issue_cnt=1.
- lw $5,0($1) back-to-back with add $6,$5,$2, out_ready=1, LOAD_DELAY=1 -> add held one cycle (in_ready=0), one out_valid=0 cycle, add issues on the following edge with out_dst=6, stall_cnt=1.
- LOAD_DELAY=2: lw $5, then one idle cycle, then add $6,$5,$2 -> exactly one hazard cycle, stall_cnt=1. A consumer of $0 after lw $0 -> no stall.
- Hold out_ready=0 for 3 cycles with ori $4,$4,0x8001 issued -> outputs stable, in_ready=0, out_imm=0x00008001. Release -> next instruction accepted same cycle.
- op 0x3F, and separately REGIMM with rt=00010 -> out_illegal=1, out_ctrl=0, out_dst=0, out_valid=1.
- flush asserted during a load-use stall -> out_valid=0 next cycle, owed=0, and the dependent instruction is accepted the cycle after flush drops. Separately, force issue_cnt to saturate -> it stays at all-ones.

Source files
------------

// File: rtl/decode_stage.sv
// Registered MIPS-I decode stage with valid/ready on both sides, illegal-encoding
// flagging, a parametrised load-use interlock and saturating issue/stall counters.
module decode_stage #(
    parameter int PC_W       = 32,
    parameter int LOAD_DELAY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [13:0]      out_ctrl,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_dst,
    output logic [31:0]      out_imm,
    output logic [PC_W-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int OW_W = (LOAD_DELAY < 2) ? 1 : $clog2(LOAD_DELAY + 1);

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [1:0] RD_RT   = 2'b00;
    localparam logic [1:0] RD_RD   = 2'b01;
    localparam logic [1:0] RD_R31  = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] IMM_SEXT = 2'd0;
    localparam logic [1:0] IMM_ZEXT = 2'd1;
    localparam logic [1:0] IMM_LUI  = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    assign op    = in_instr[31:26];
    assign rs    = in_instr[25:21];
    assign rt    = in_instr[20:16];
    assign rd    = in_instr[15:11];
    assign fn    = in_instr[5:0];
    assign imm16 = in_instr[15:0];

    logic [3:0]  alu_op;
    logic        alu_src, mem_wr, mem_rd, ld_signed, mem_to_reg, no_wb, illegal;
    logic [1:0]  reg_dst, size, imm_mode;
    logic        is_load, rs_used, rt_used;
    logic [13:0] ctrl_dec;
    logic [31:0] imm_dec;
    logic [4:0]  dst_dec;

    always_comb begin
        alu_op     = 4'd0;
        alu_src    = 1'b0;
        reg_dst    = RD_RT;
        size       = SZ_WORD;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        ld_signed  = 1'b0;
        mem_to_reg = 1'b0;
        no_wb      = 1'b0;
        illegal    = 1'b0;
        imm_mode   = IMM_SEXT;
        is_load    = 1'b0;
        rt_used    = 1'b0;
        case (op)
            OP_RTYPE: begin
                rt_used = 1'b1;
                case (fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: reg_dst = RD_RD;
                    6'h08:   no_wb   = 1'b1;
                    6'h09:   reg_dst = RD_R31;
                    default: illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                alu_op = 4'd1;
                case (rt)
                    5'b00000, 5'b00001: no_wb   = 1'b1;
                    5'b10000, 5'b10001: reg_dst = RD_R31;
                    default:            illegal = 1'b1;
                endcase
            end
            OP_J, OP_BLEZ, OP_BGTZ: begin
                alu_op = 4'd1;
                no_wb  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_op  = 4'd1;
                no_wb   = 1'b1;
                rt_used = 1'b1;
            end
            OP_JAL: begin
                alu_op  = 4'd1;
                reg_dst = RD_R31;
            end
            // Immediate ALU ops take consecutive ALUOp codes 1..8 in opcode order
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                alu_op  = 4'(op[2:0]) + 4'd1;
                alu_src = 1'b1;
                if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) imm_mode = IMM_ZEXT;
                else if (op == OP_LUI)                              imm_mode = IMM_LUI;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                alu_op     = 4'd1;
                alu_src    = 1'b1;
                mem_rd     = 1'b1;
                mem_to_reg = 1'b1;
                is_load    = 1'b1;
                ld_signed  = (op == OP_LB) || (op == OP_LH);
                if (op == OP_LB || op == OP_LBU)      size = SZ_BYTE;
                else if (op == OP_LH || op == OP_LHU) size = SZ_HALF;
            end
            OP_SB, OP_SH, OP_SW: begin
                alu_op  = 4'd1;
                alu_src = 1'b1;
                mem_wr  = 1'b1;
                no_wb   = 1'b1;
                rt_used = 1'b1;
                if (op == OP_SB)      size = SZ_BYTE;
                else if (op == OP_SH) size = SZ_HALF;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign rs_used  = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
    assign ctrl_dec = illegal ? 14'd0
                              : {alu_op, alu_src, reg_dst, size, mem_wr, mem_rd,
                                 ld_signed, mem_to_reg, no_wb};

    always_comb begin
        case (imm_mode)
            IMM_ZEXT: imm_dec = {16'd0, imm16};
            IMM_LUI:  imm_dec = {imm16, 16'd0};
            default:  imm_dec = {{16{imm16[15]}}, imm16};
        endcase
    end

    always_comb begin
        case (reg_dst)
            RD_RD:   dst_dec = rd;
            RD_R31:  dst_dec = 5'd31;
            default: dst_dec = rt;
        endcase
        if (no_wb || illegal) dst_dec = 5'd0;
    end

    logic             valid_q, valid_d, ill_q, ill_d;
    logic [13:0]      ctrl_q, ctrl_d;
    logic [4:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, dst_q, dst_d;
    logic [31:0]      imm_q, imm_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [OW_W-1:0]  owed_q, owed_d;
    logic [4:0]       ld_dst_q, ld_dst_d;
    logic [CNT_W-1:0] issue_q, issue_d, stall_q, stall_d;
    logic             slot_free, hazard, accept;

    assign slot_free = !valid_q || out_ready;
    assign hazard    = in_valid && (owed_q != '0) && (ld_dst_q != 5'd0) &&
                       ((rs_used && (rs == ld_dst_q)) || (rt_used && (rt == ld_dst_q)));
    assign in_ready  = slot_free && !flush && !hazard;
    assign accept    = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        dst_d    = dst_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        ill_d    = ill_q;
        owed_d   = owed_q;
        ld_dst_d = ld_dst_q;
        issue_d  = issue_q;
        stall_d  = stall_q;
        if (flush) begin
            valid_d = 1'b0;
            owed_d  = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_dec;
            rs_d    = rs;
            rt_d    = rt;
            rd_d    = rd;
            dst_d   = dst_dec;
            imm_d   = imm_dec;
            pc_d    = in_pc;
            ill_d   = illegal;
            issue_d = sat_inc(issue_q);
            // A load to $0 never creates a dependency, so it clears the interlock
            if (is_load && (dst_dec != 5'd0)) begin
                owed_d   = OW_W'(LOAD_DELAY);
                ld_dst_d = dst_dec;
            end else begin
                owed_d = '0;
            end
        end else if (slot_free) begin
            valid_d = 1'b0;
            if (owed_q != '0) owed_d = owed_q - OW_W'(1);
        end
        if (hazard && slot_free && !flush) stall_d = sat_inc(stall_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            ill_q    <= 1'b0;
            owed_q   <= '0;
            ld_dst_q <= '0;
            issue_q  <= '0;
            stall_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            dst_q    <= dst_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            ill_q    <= ill_d;
            owed_q   <= owed_d;
            ld_dst_q <= ld_dst_d;
            issue_q  <= issue_d;
            stall_q  <= stall_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_ctrl    = ctrl_q;
    assign out_rs      = rs_q;
    assign out_rt      = rt_q;
    assign out_rd      = rd_q;
    assign out_dst     = dst_q;
    assign out_imm     = imm_q;
    assign out_pc      = pc_q;
    assign out_illegal = ill_q;
    assign issue_cnt   = issue_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (LOAD_DELAY=1 / LOAD_DELAY=2 with 4-bit
// counters) share stimulus; sel picks which one a scenario observes.
module tb_decode_stage;

    typedef struct packed {
        logic [13:0] ctrl;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, flush, out_ready, sel;
    logic [31:0] in_instr, in_pc;

    logic        rdy1, v1, ill1, rdy2, v2, ill2;
    logic [13:0] ctrl1, ctrl2;
    logic [4:0]  rs1, rt1, rd1, dst1, rs2, rt2, rd2, dst2;
    logic [31:0] imm1, pc1, imm2, pc2;
    logic [15:0] ic1, sc1;
    logic [3:0]  ic2, sc2;

    decode_stage u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(v1),
        .out_ready(out_ready), .out_ctrl(ctrl1), .out_rs(rs1), .out_rt(rt1),
        .out_rd(rd1), .out_dst(dst1), .out_imm(imm1), .out_pc(pc1),
        .out_illegal(ill1), .issue_cnt(ic1), .stall_cnt(sc1)
    );

    decode_stage #(.LOAD_DELAY(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(v2),
        .out_ready(out_ready), .out_ctrl(ctrl2), .out_rs(rs2), .out_rt(rt2),
        .out_rd(rd2), .out_dst(dst2), .out_imm(imm2), .out_pc(pc2),
        .out_illegal(ill2), .issue_cnt(ic2), .stall_cnt(sc2)
    );

    logic        o_ready, o_valid, o_ill;
    logic [13:0] o_ctrl;
    logic [4:0]  o_rs, o_rt, o_rd, o_dst;
    logic [31:0] o_imm, o_pc;
    logic [15:0] o_issue, o_stall;

    assign o_ready = sel ? rdy2  : rdy1;
    assign o_valid = sel ? v2    : v1;
    assign o_ill   = sel ? ill2  : ill1;
    assign o_ctrl  = sel ? ctrl2 : ctrl1;
    assign o_rs    = sel ? rs2   : rs1;
    assign o_rt    = sel ? rt2   : rt1;
    assign o_rd    = sel ? rd2   : rd1;
    assign o_dst   = sel ? dst2  : dst1;
    assign o_imm   = sel ? imm2  : imm1;
    assign o_pc    = sel ? pc2   : pc1;
    assign o_issue = sel ? {12'd0, ic2} : ic1;
    assign o_stall = sel ? {12'd0, sc2} : sc1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t obs[$];
    exp_t got, want;
    int   w;

    localparam logic [31:0] I_ADDI   = 32'h2043FFFC;
    localparam logic [31:0] I_ADD    = 32'h00A23020;
    localparam logic [31:0] I_ORI    = 32'h34848001;
    localparam logic [31:0] I_LUI    = 32'h3C071234;
    localparam logic [31:0] I_LB     = 32'h8128FFFF;
    localparam logic [31:0] I_SW     = 32'hAFA30004;
    localparam logic [31:0] I_JAL    = 32'h0C000040;
    localparam logic [31:0] I_JR     = 32'h03E00008;
    localparam logic [31:0] I_LHU    = 32'h942A0002;
    localparam logic [31:0] I_BGEZAL = 32'h04910010;
    localparam logic [31:0] I_LW5    = 32'h8C250000;
    localparam logic [31:0] I_LW0    = 32'h8C200000;
    localparam logic [31:0] I_ADD0   = 32'h00023020;
    localparam logic [31:0] I_XORI   = 32'h382900FF;
    localparam logic [31:0] I_BAD_OP = 32'hFC000000;
    localparam logic [31:0] I_BAD_RI = 32'h04020005;

    function automatic exp_t mk(input logic [13:0] c, input logic [4:0] d,
                                input logic [31:0] i, input logic [31:0] p, input logic il);
        exp_t e;
        e.ctrl = c; e.dst = d; e.imm = i; e.pc = p; e.ill = il;
        return e;
    endfunction

    // Capture every bundle the execute side actually takes
    always @(negedge clk) begin
        if (rst_n && o_valid && out_ready) obs.push_back(mk(o_ctrl, o_dst, o_imm, o_pc, o_ill));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic s);
        sel = s; rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        step(); step();
        rst_n = 1'b1;
        sb.delete(); obs.delete();
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e, output int waited);
        in_valid = 1'b1; in_instr = ins; in_pc = pc; waited = 0;
        #1;
        while (!o_ready && waited < 20) begin step(); waited++; end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL send_timeout instr=%h in_ready=%b required=1", ins, o_ready); end
        else sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0; rst_n = 1'b0; in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h44; out_ready = 1'b0; flush = 1'b0;
        step(); step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_ctrl !== 14'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", o_ctrl); end
        checks++; if ({o_dst, o_imm, o_pc, o_ill} !== '0) begin errors++; $display("FAIL reset_payload got dst=%0d imm=%h pc=%h ill=%b want 0", o_dst, o_imm, o_pc, o_ill); end
        checks++; if (o_issue !== 16'd0 || o_stall !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", o_issue, o_stall); end
        sel = 1'b1; #1;
        checks++; if (o_valid !== 1'b0 || o_issue !== 16'd0) begin errors++; $display("FAIL reset_dut2 got valid=%b issue=%0d want 0/0", o_valid, o_issue); end
        in_valid = 1'b0; rst_n = 1'b1; sel = 1'b0;
    endtask

    task automatic test_addi();
        do_reset(1'b0);
        send(I_ADDI, 32'h100, mk(14'h0600, 5'd3, 32'hFFFFFFFC, 32'h100, 1'b0), w);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", o_valid); end
        checks++; if (o_issue !== 16'd1) begin errors++; $display("FAIL addi_issue got %0d want 1", o_issue); end
        checks++; if ({o_rs, o_rt, o_rd} !== {5'd2, 5'd3, 5'd31}) begin errors++; $display("FAIL addi_fields got %0d/%0d/%0d want 2/3/31", o_rs, o_rt, o_rd); end
        step();
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL addi_sb_count got %0d want %0d", obs.size(), sb.size()); end
        while (obs.size() != 0 && sb.size() != 0) begin
            got = obs.pop_front(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL addi_bundle got %h want %h", got, want); end
        end
    endtask

    task automatic test_decode_mix();
        do_reset(1'b0);
        send(I_ADD,    32'h200, mk(14'h0080, 5'd6,  32'h00003020, 32'h200, 1'b0), w);
        send(I_ORI,    32'h204, mk(14'h1A00, 5'd4,  32'h00008001, 32'h204, 1'b0), w);
        send(I_LUI,    32'h208, mk(14'h2200, 5'd7,  32'h12340000, 32'h208, 1'b0), w);
        send(I_LB,     32'h20C, mk(14'h064E, 5'd8,  32'hFFFFFFFF, 32'h20C, 1'b0), w);
        send(I_SW,     32'h210, mk(14'h0611, 5'd0,  32'h00000004, 32'h210, 1'b0), w);
        send(I_JAL,    32'h214, mk(14'h0500, 5'd31, 32'h00000040, 32'h214, 1'b0), w);
        send(I_JR,     32'h218, mk(14'h0001, 5'd0,  32'h00000008, 32'h218, 1'b0), w);
        send(I_LHU,    32'h21C, mk(14'h062A, 5'd10, 32'h00000002, 32'h21C, 1'b0), w);
        send(I_BGEZAL, 32'h220, mk(14'h0500, 5'd31, 32'h00000010, 32'h220, 1'b0), w);
        checks++; if (o_issue !== 16'd9) begin errors++; $display("FAIL mix_issue got %0d want 9", o_issue); end
        step();
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL mix_sb_count got %0d want %0d", obs.size(), sb.size()); end
        while (obs.size() != 0 && sb.size() != 0) begin
            got = obs.pop_front(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL mix_bundle got %h want %h", got, want); end
        end
    endtask

    task automatic test_load_use();
        do_reset(1'b0);
        send(I_LW5, 32'h300, mk(14'h060A, 5'd5, 32'h0, 32'h300, 1'b0), w);
        in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h304; #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL lu_held in_ready got %b want 0", o_ready); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble out_valid got %b want 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL lu_release in_ready got %b want 1", o_ready); end
        checks++; if (o_stall !== 16'd1) begin errors++; $display("FAIL lu_stall got %0d want 1", o_stall); end
        sb.push_back(mk(14'h0080, 5'd6, 32'h00003020, 32'h304, 1'b0));
        step(); in_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_dst !== 5'd6) begin errors++; $display("FAIL lu_issue got valid=%b dst=%0d want 1/6", o_valid, o_dst); end
        checks++; if (o_issue !== 16'd2) begin errors++; $display("FAIL lu_issue_cnt got %0d want 2", o_issue); end
        step();
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL lu_sb_count got %0d want %0d", obs.size(), sb.size()); end
        while (obs.size() != 0 && sb.size() != 0) begin
            got = obs.pop_front(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL lu_bundle got %h want %h", got, want); end
        end
    endtask

    task automatic test_load_delay2();
        do_reset(1'b1);
        send(I_LW5, 32'h400, mk(14'h060A, 5'd5, 32'h0, 32'h400, 1'b0), w);
        step();
        send(I_ADD, 32'h404, mk(14'h0080, 5'd6, 32'h00003020, 32'h404, 1'b0), w);
        checks++; if (w !== 1) begin errors++; $display("FAIL ld2_wait got %0d want 1", w); end
        checks++; if (o_stall !== 16'd1) begin errors++; $display("FAIL ld2_stall got %0d want 1", o_stall); end
        send(I_LW0, 32'h408, mk(14'h060A, 5'd0, 32'h0, 32'h408, 1'b0), w);
        send(I_ADD0, 32'h40C, mk(14'h0080, 5'd6, 32'h00003020, 32'h40C, 1'b0), w);
        checks++; if (w !== 0) begin errors++; $display("FAIL ld2_r0_wait got %0d want 0", w); end
        checks++; if (o_stall !== 16'd1) begin errors++; $display("FAIL ld2_r0_stall got %0d want 1", o_stall); end
        step();
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL ld2_sb_count got %0d want %0d", obs.size(), sb.size()); end
        while (obs.size() != 0 && sb.size() != 0) begin
            got = obs.pop_front(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL ld2_bundle got %h want %h", got, want); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        send(I_ORI, 32'h500, mk(14'h1A00, 5'd4, 32'h00008001, 32'h500, 1'b0), w);
        out_ready = 1'b0; in_pc = 32'h504;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1); in_instr = (i == 2) ? I_XORI : I_ADD; #1;
            checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, o_ready); end
            checks++; if (o_valid !== 1'b1 || o_imm !== 32'h00008001 || o_ctrl !== 14'h1A00 || o_pc !== 32'h500)
                begin errors++; $display("FAIL bp_hold cycle %0d got v=%b imm=%h ctrl=%h pc=%h want 1/00008001/1a00/500", i, o_valid, o_imm, o_ctrl, o_pc); end
            step();
        end
        in_valid = 1'b1; in_instr = I_XORI; out_ready = 1'b1; #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got %b want 1", o_ready); end
        sb.push_back(mk(14'h1E00, 5'd9, 32'h000000FF, 32'h504, 1'b0));
        step(); in_valid = 1'b0;
        checks++; if (o_dst !== 5'd9 || o_imm !== 32'h000000FF) begin errors++; $display("FAIL bp_next got dst=%0d imm=%h want 9/000000ff", o_dst, o_imm); end
        step();
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL bp_sb_count got %0d want %0d", obs.size(), sb.size()); end
        while (obs.size() != 0 && sb.size() != 0) begin
            got = obs.pop_front(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL bp_bundle got %h want %h", got, want); end
        end
    endtask

    task automatic test_illegal();
        do_reset(1'b0);
        send(I_BAD_OP, 32'h600, mk(14'h0, 5'd0, 32'h0, 32'h600, 1'b1), w);
        checks++; if (o_valid !== 1'b1 || o_ill !== 1'b1 || o_ctrl !== 14'd0 || o_dst !== 5'd0)
            begin errors++; $display("FAIL ill_op got v=%b ill=%b ctrl=%h dst=%0d want 1/1/0/0", o_valid, o_ill, o_ctrl, o_dst); end
        send(I_BAD_RI, 32'h604, mk(14'h0, 5'd0, 32'h5, 32'h604, 1'b1), w);
        checks++; if (o_valid !== 1'b1 || o_ill !== 1'b1 || o_ctrl !== 14'd0 || o_dst !== 5'd0)
            begin errors++; $display("FAIL ill_regimm got v=%b ill=%b ctrl=%h dst=%0d want 1/1/0/0", o_valid, o_ill, o_ctrl, o_dst); end
        step();
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL ill_sb_count got %0d want %0d", obs.size(), sb.size()); end
        while (obs.size() != 0 && sb.size() != 0) begin
            got = obs.pop_front(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL ill_bundle got %h want %h", got, want); end
        end
    endtask

    task automatic test_flush();
        do_reset(1'b0);
        send(I_LW5, 32'h700, mk(14'h060A, 5'd5, 32'h0, 32'h700, 1'b0), w);
        in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h704; flush = 1'b1; #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready got %b want 0", o_ready); end
        step(); flush = 1'b0; #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %b want 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL fl_owed_cleared in_ready got %b want 1", o_ready); end
        checks++; if (o_stall !== 16'd0) begin errors++; $display("FAIL fl_stall got %0d want 0", o_stall); end
        sb.push_back(mk(14'h0080, 5'd6, 32'h00003020, 32'h704, 1'b0));
        step(); in_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_dst !== 5'd6) begin errors++; $display("FAIL fl_issue got v=%b dst=%0d want 1/6", o_valid, o_dst); end
        step();
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL fl_sb_count got %0d want %0d", obs.size(), sb.size()); end
        while (obs.size() != 0 && sb.size() != 0) begin
            got = obs.pop_front(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL fl_bundle got %h want %h", got, want); end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset(1'b1);
        send(I_LW5, 32'h800, mk(14'h060A, 5'd5, 32'h0, 32'h800, 1'b0), w);
        in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h804; #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rms_held in_ready got %b want 0", o_ready); end
        rst_n = 1'b0;
        step(); rst_n = 1'b1; #1;
        checks++; if (o_valid !== 1'b0 || o_issue !== 16'd0) begin errors++; $display("FAIL rms_empty got v=%b issue=%0d want 0/0", o_valid, o_issue); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rms_owed in_ready got %b want 1", o_ready); end
        in_valid = 1'b0;
        step();
        sb.delete(); obs.delete();
    endtask

    task automatic test_saturate();
        do_reset(1'b1);
        for (int i = 0; i < 15; i++) send(I_ADDI, 32'h900 + 4 * i, mk(14'h0600, 5'd3, 32'hFFFFFFFC, 32'h900 + 4 * i, 1'b0), w);
        checks++; if (o_issue !== 16'd15) begin errors++; $display("FAIL sat_reach got %0d want 15", o_issue); end
        for (int i = 0; i < 3; i++) send(I_ADDI, 32'hA00 + 4 * i, mk(14'h0600, 5'd3, 32'hFFFFFFFC, 32'hA00 + 4 * i, 1'b0), w);
        checks++; if (o_issue !== 16'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", o_issue); end
        step();
        checks++; if (obs.size() != sb.size()) begin errors++; $display("FAIL sat_sb_count got %0d want %0d", obs.size(), sb.size()); end
        while (obs.size() != 0 && sb.size() != 0) begin
            got = obs.pop_front(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL sat_bundle got %h want %h", got, want); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        sel = 1'b0; rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        test_reset();
        test_addi();
        test_decode_mix();
        test_load_use();
        test_load_delay2();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid_stall();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
